// File: rtl/qam_mapper_param.sv
// Serial-to-symbol QAM mapper: gathers MSB-first bits and emits Gray-coded I/Q
// pairs (QPSK or 16-QAM) with valid/ready handshakes on both sides.
module qam_mapper_param #(
  parameter int OUT_W = 4,
  parameter int AMP   = 4,
  parameter int STEP  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic signed [OUT_W-1:0] I,
  output logic signed [OUT_W-1:0] Q,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic [CNT_W-1:0]        sym_count
);

  localparam logic signed [OUT_W-1:0] AMP_V = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] LVL1  = OUT_W'(STEP);
  localparam logic signed [OUT_W-1:0] LVL3  = OUT_W'(3 * STEP);

  logic [1:0]              bit_cnt;
  logic                    mode_q;
  logic [2:0]              shift_q;
  logic                    last_bit;
  logic                    accept;
  logic [3:0]              sym_bits;
  logic signed [OUT_W-1:0] i_map;
  logic signed [OUT_W-1:0] q_map;

  function automatic logic signed [OUT_W-1:0] gray_level(input logic [1:0] b);
    case (b)
      2'b00:   return -LVL3;
      2'b01:   return -LVL1;
      2'b11:   return LVL1;
      default: return LVL3;
    endcase
  endfunction

  // A symbol is never final at count 0, so the latched mode is always valid here.
  assign last_bit  = mode_q ? (bit_cnt == 2'd3) : (bit_cnt == 2'd1);
  assign bit_ready = !last_bit || !sym_valid || sym_ready;
  assign accept    = bit_valid && bit_ready;
  assign sym_bits  = {shift_q, bit_in};

  always_comb begin
    i_map = '0;
    q_map = '0;
    if (mode_q) begin
      i_map = gray_level(sym_bits[3:2]);
      q_map = gray_level(sym_bits[1:0]);
    end else begin
      i_map = sym_bits[0] ? AMP_V : -AMP_V;
      q_map = sym_bits[1] ? -AMP_V : AMP_V;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      I         <= '0;
      Q         <= '0;
      sym_valid <= 1'b0;
      sym_count <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      mode_q    <= 1'b0;
    end else begin
      if (sym_valid && sym_ready)
        sym_valid <= 1'b0;
      if (accept) begin
        shift_q <= {shift_q[1:0], bit_in};
        if (bit_cnt == 2'd0)
          mode_q <= mode;
        // A completing symbol overrides the consumption clear above: no bubble.
        if (last_bit) begin
          I         <= i_map;
          Q         <= q_map;
          sym_valid <= 1'b1;
          sym_count <= sym_count + CNT_W'(1);
          bit_cnt   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qam_mapper_param.sv
// Scoreboard bench for qam_mapper_param: a bench-side model predicts each symbol
// on final-bit acceptance; a monitor compares it when the DUT hands it off.
module tb_qam_mapper_param;

  localparam int AMP  = 4;
  localparam int STEP = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mode = 1'b0;
  logic              bit_in = 1'b0;
  logic              bit_valid = 1'b0;
  logic              sym_ready = 1'b1;
  logic              bit_ready, bit_ready2;
  logic signed [3:0] I, Q, I2, Q2;
  logic              sym_valid, sym_valid2;
  logic [15:0]       sym_count;
  logic [1:0]        sym_count2;

  typedef struct {
    int i;
    int q;
    int cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mcnt = 0;
  logic        mmode = 1'b0;
  logic [3:0]  mbits = '0;
  int          mtotal = 0;

  qam_mapper_param #(.OUT_W(4), .AMP(AMP), .STEP(STEP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .I(I), .Q(Q), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_count(sym_count)
  );

  qam_mapper_param #(.OUT_W(4), .AMP(AMP), .STEP(STEP), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready2), .I(I2), .Q(Q2), .sym_valid(sym_valid2),
    .sym_ready(sym_ready), .sym_count(sym_count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qam_level(input logic [1:0] b);
    case (b)
      2'b00:   return -3 * STEP;
      2'b01:   return -STEP;
      2'b11:   return STEP;
      default: return 3 * STEP;
    endcase
  endfunction

  task automatic model_accept(input logic b);
    exp_t e;
    if (mcnt == 0) mmode = mode;
    mbits = {mbits[2:0], b};
    mcnt++;
    if (mcnt == (mmode ? 4 : 2)) begin
      mtotal++;
      if (mmode) begin
        e.i = qam_level(mbits[3:2]);
        e.q = qam_level(mbits[1:0]);
      end else begin
        case (mbits[1:0])
          2'b00:   begin e.i = -AMP; e.q =  AMP; end
          2'b01:   begin e.i =  AMP; e.q =  AMP; end
          2'b11:   begin e.i =  AMP; e.q = -AMP; end
          default: begin e.i = -AMP; e.q = -AMP; end
        endcase
      end
      e.cnt = mtotal;
      sb.push_back(e);
      mcnt = 0;
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after the accepting edge.
  task automatic send_bit(input logic b);
    int n = 0;
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    while (!bit_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bit_ready) begin
      check("bit_ready_timeout", 0, 1);
      bit_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bit_valid = 1'b0;
      model_accept(b);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    mcnt   = 0;
    mmode  = 1'b0;
    mbits  = '0;
    mtotal = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && sym_valid && sym_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("sym_I", int'(I), e.i);
        check("sym_Q", int'(Q), e.q);
        check("sym_count", int'(sym_count), e.cnt % 65536);
        check("sym_count_w2", int'(sym_count2), e.cnt % 4);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_I", int'(I), 0);
    check("rst_Q", int'(Q), 0);
    check("rst_valid", int'(sym_valid), 0);
    check("rst_count", int'(sym_count), 0);
    @(posedge clk); #1;

    // QPSK free flow
    mode = 1'b0; sym_ready = 1'b1;
    send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0);
    idle(2);
    @(negedge clk);
    check("qpsk_valid_low", int'(sym_valid), 0);
    check("qpsk_count", int'(sym_count), 2);
    check("qpsk_hold_I", int'(I), -4);
    check("qpsk_hold_Q", int'(Q), -4);
    @(posedge clk); #1;

    // 16-QAM
    mode = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    idle(2);

    // QPSK backpressure
    mode = 1'b0; sym_ready = 1'b0;
    send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1);
    bit_in = 1'b0; bit_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", int'(bit_ready), 0);
      check("bp_valid", int'(sym_valid), 1);
      check("bp_I", int'(I), 4);
      check("bp_Q", int'(Q), 4);
    end
    @(posedge clk); #1;
    sym_ready = 1'b1;
    @(negedge clk);
    check("bp_release", int'(bit_ready), 1);
    @(posedge clk); #1;
    sym_ready = 1'b0; bit_valid = 1'b0;
    model_accept(1'b0);
    @(negedge clk);
    check("bp_no_bubble", int'(sym_valid), 1);
    check("bp_new_I", int'(I), -4);
    check("bp_new_Q", int'(Q), -4);
    @(posedge clk); #1;
    sym_ready = 1'b1;
    idle(2);

    // Mode change mid-symbol is ignored until the next symbol
    mode = 1'b0;
    send_bit(1'b1);
    mode = 1'b1;
    send_bit(1'b0);
    idle(1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    check("mc_partial_count", int'(sym_count), mtotal);
    check("mc_partial_valid", int'(sym_valid), 0);
    @(posedge clk); #1;
    send_bit(1'b0);
    idle(2);

    // Reset mid-symbol discards partial bits
    mode = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("pre_reset_sb_empty", sb.size(), 0);
    do_reset();
    @(negedge clk);
    check("mid_rst_I", int'(I), 0);
    check("mid_rst_Q", int'(Q), 0);
    check("mid_rst_valid", int'(sym_valid), 0);
    check("mid_rst_count", int'(sym_count), 0);
    check("mid_rst_count_w2", int'(sym_count2), 0);
    @(posedge clk); #1;
    mode = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    idle(2);

    // Five more symbols: narrow counter wraps through 3 -> 0
    for (int k = 0; k < 5; k++) begin
      send_bit(k[0]); send_bit(k[1]);
    end
    idle(3);
    check("sb_drained", sb.size(), 0);
    check("final_count", int'(sym_count), 6);
    check("final_count_w2", int'(sym_count2), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_mapper_param.md
Name: qam_mapper_param

Overview:
Parametrised serial-to-symbol QAM mapper, the next generation of the fixed 4-level QPSK mapper. It collects a serial bit stream from the convolutional encoder and emits Gray-coded I/Q symbol pairs to the modulator/DAC path. It supports runtime selection of QPSK (2 bits/symbol) or 16-QAM (4 bits/symbol) and uses a valid/ready handshake on both sides instead of free-running sample clocks. It sits between the channel encoder and the I/Q upsampling filter.

Parameters:
OUT_W, 4, width of signed I and Q outputs.
AMP, 4, QPSK level magnitude; must fit in signed OUT_W.
STEP, 2, 16-QAM unit level; levels are ±1·STEP and ±3·STEP; 3·STEP must fit in signed OUT_W.
CNT_W, 16, width of the emitted-symbol counter.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
mode  in  1  0 = QPSK, 1 = 16-QAM; sampled only at symbol start.
bit_in  in  1  serial data bit, MSB of symbol first.
bit_valid  in  1  bit_in valid.
bit_ready  out  1  mapper can accept bit_in this cycle (combinational).
I  out  OUT_W  signed in-phase symbol value.
Q  out  OUT_W  signed quadrature symbol value.
sym_valid  out  1  I/Q hold an unconsumed symbol.
sym_ready  in  1  downstream accepts I/Q this cycle.
sym_count  out  CNT_W  number of symbols emitted, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high): I=0, Q=0, sym_valid=0, sym_count=0, bit counter=0, shift register=0, latched mode=0. Reset mid-symbol discards partial bits.
- Bit acceptance: a bit is accepted when bit_valid && bit_ready. The latched mode sets bps, which is 2 for QPSK and 4 for 16-QAM.
- bit_ready = 1 when the accepted-bit count < bps-1. For the final bit of a symbol, bit_ready = !sym_valid || sym_ready.
- Mode latching: mode is latched on acceptance of the first bit of a symbol (count = 0). Changes to mode mid-symbol are ignored until the next symbol.
- Bit ordering: bits shift in MSB first, so the first bit becomes b[bps-1].
- Symbol output: on the edge where the final bit is accepted, I and Q load the mapped values, sym_valid goes to 1, sym_count increments, and the bit counter clears. Latency is 0 cycles after the final-bit acceptance edge.
- QPSK map (b1 b0 → I, Q): 00 → (−AMP, +AMP), 01 → (+AMP, +AMP), 11 → (+AMP, −AMP), 10 → (−AMP, −AMP).
- 16-QAM map: b3 b2 set I and b1 b0 set Q, using the Gray level map 00 → −3·STEP, 01 → −1·STEP, 11 → +1·STEP, 10 → +3·STEP. Results are sign-extended to OUT_W.
- Output handshake: a symbol is consumed when sym_valid && sym_ready. After consumption with no new symbol completing, sym_valid goes to 0 and I/Q hold their last values.
- Simultaneous events: if consumption and final-bit acceptance occur in the same cycle, I/Q take the new symbol and sym_valid stays 1. No bubble and no loss.
- Backpressure: while sym_valid=1 and sym_ready=0, non-final bits of the next symbol are still accepted. The final bit stalls (bit_ready=0) until the slot frees.
- sym_ready while sym_valid=0 has no effect.
- sym_count wraps from 2^CNT_W−1 to 0 without a flag.
- bit_valid=0 gaps of any length are allowed mid-symbol; the partial state is held.

Test Plan:
- QPSK, sym_ready=1, bits 0,1 then 1,0 → first symbol I=+4, Q=+4; second symbol I=−4, Q=−4. sym_valid is high for 1 cycle each; sym_count=2.
- 16-QAM, bits 1,0,0,1 → I=+6, Q=−2. Bits 0,0,1,1 → I=−6, Q=+2. Output value must equal the sign-extended 4-bit value.
- Backpressure in QPSK: hold sym_ready=0 after the first symbol and feed 4 more bits → the third bit is accepted and the fourth sees bit_ready=0. I/Q stay on the first symbol. Raising sym_ready for 1 cycle loads the second symbol in that same cycle with sym_valid continuously 1.
- Mode change mid-symbol: start in QPSK, accept 1 bit, set mode=1, accept 1 bit → a QPSK symbol is emitted. The next symbol needs 4 bits.
- Reset mid-symbol: in 16-QAM accept 3 bits, then assert reset for 1 cycle → all outputs 0. The following 2 bits with mode=0 emit a QPSK symbol, proving the partial bits were discarded.
- CNT_W=2 override: emit 5 symbols → sym_count sequence 1, 2, 3, 0, 1.
